// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the load/store memory access unit.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = 4;

    // Access attributes captured on an accepted start.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       se;
        logic [1:0] a;
    } req_t;

    // Reserved size 2'b11 falls through to word everywhere.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    lane_be = 4'b0001 << a;
            SZ_H:    lane_be = a[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_B:    lane_wdata = {4{wd[7:0]}};
            SZ_H:    lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side request/response bus of the access unit.
interface mem_access_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_ext.sv
// Load lane extraction and sign/zero extension; shared with the register-file write path.
module mem_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        SE_s,
    output logic [31:0] result
);

    logic [7:0]  byte_l;
    logic [15:0] half_l;

    assign byte_l = rdata[{a, 3'b000} +: 8];
    assign half_l = a[1] ? rdata[31:16] : rdata[15:0];

    // SE_s high selects zero extension (LBU/LHU).
    always_comb begin
        result = rdata;
        case (size)
            SZ_B:    result = SE_s ? {24'b0, byte_l} : {{24{byte_l[7]}}, byte_l};
            SZ_H:    result = SE_s ? {16'b0, half_l} : {{16{half_l[15]}}, half_l};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer with ack timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of issuing.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TO_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic              Mem_write,
    input  logic [1:0]        Size_s,
    input  logic              SE_s,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    mem_access_unit_if.master mem,
    output logic [31:0]       MDR,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              misalign
);

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    req_t             req_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [31:0]      mdr_q;
    logic             err_q;
    logic [31:0]      ext_res;
    logic             accept;
    logic             trap;

    assign accept = start && (state_q == ST_IDLE);

    mem_ext u_ext (
        .rdata  (mem.mem_rdata),
        .a      (req_q.a),
        .size   (req_q.size),
        .SE_s   (req_q.se),
        .result (ext_res)
    );

`ifdef MISALIGN_TRAP_EN
    logic mis_q;

    assign trap = misaligned(Size_s, addr[1:0]);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)       mis_q <= 1'b0;
        else if (accept) mis_q <= trap;
    end

    assign misalign = mis_q;
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        req_q   <= '{we: Mem_write, size: Size_s, se: SE_s, a: addr[1:0]};
                        addr_q  <= {addr[31:2], 2'b00};
                        be_q    <= lane_be(Size_s, addr[1:0]);
                        wdata_q <= lane_wdata(Size_s, wdata);
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= trap ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (mem.mem_ack) begin
                        if (!req_q.we) mdr_q <= ext_res;
                        state_q <= ST_RESP;
                    end else if (cnt_q == CNT_W'(TO_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_we    = req_q.we;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    assign MDR  = mdr_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_RESP);
    assign err  = err_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TO_CYCLES, default 15, meaning the maximum number of wait cycles for mem_ack before timeout (range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst_, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle access request pulse from the control unit.
REQ-005 The block SHALL have port Mem_write, input, 1 bit: 1 = store, 0 = load; sampled only with start.
REQ-006 The block SHALL have port Size_s, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
REQ-007 The block SHALL have port SE_s, input, 1 bit: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
REQ-008 The block SHALL have ports addr, input, 32 bits (byte address) and wdata, input, 32 bits (store data in the low lanes).
REQ-009 The block SHALL have memory-side ports: mem_req out 1; mem_we out 1; mem_addr out 32 (word-aligned, [1:0]=00); mem_be out 4; mem_wdata out 32; mem_rdata in 32; mem_ack in 1.
REQ-010 The block SHALL have CU/datapath-side outputs: MDR out 32 (extended load result); busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky timeout flag); misalign out 1.

Function
REQ-011 The FSM SHALL have the states IDLE, REQ, RESP, with the following transitions: IDLE -> REQ on start; REQ -> RESP on mem_ack or on timeout; RESP -> IDLE unconditionally.
REQ-012 On start in IDLE, the block SHALL register addr, wdata, Size_s, SE_s and Mem_write; start while not in IDLE SHALL be ignored.
REQ-013 mem_req SHALL be high exactly while in REQ, and mem_addr/mem_we/mem_be/mem_wdata SHALL hold stable while mem_req is high.
REQ-014 Lane select SHALL use the registered addr[1:0]: byte gives be=0001<<a[1:0]; half gives be=0011<<(a[1]*2); word gives be=1111.
REQ-015 For stores, the block SHALL replicate store data across lanes: byte to {4{wdata[7:0]}}; half to {2{wdata[15:0]}}; word to wdata.
REQ-016 For loads, when mem_ack is sampled high in REQ, the block SHALL extract the lane and extend it per Size_s/SE_s, writing the result to MDR on that edge; MDR SHALL be unchanged on stores and on timeout.
REQ-017 done SHALL pulse high for exactly one cycle in RESP; minimum latency SHALL be start edge -> REQ -> ack in same cycle -> done one cycle later, i.e. 3 cycles start-to-done.
REQ-018 A 4-bit wait counter SHALL clear on entering REQ and increment each REQ cycle without ack; when it reaches TO_CYCLES, the block SHALL set err, drop mem_req and move to RESP, still pulsing done.
REQ-019 err SHALL clear only on reset or on the next accepted start.
REQ-020 busy SHALL be high in REQ and RESP, and low in IDLE.
REQ-021 mem_ack sampled outside REQ SHALL be ignored.

Reset
REQ-022 While rst_=0, the block SHALL force state IDLE, mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, MDR=0, busy=0, done=0, err=0, misalign=0 and the counter to 0.
REQ-023 Reset asserted mid-access SHALL abort immediately, with no done pulse and no MDR update.

Configuration
REQ-024 When MISALIGN_TRAP_EN is defined, a half access with a[0]=1 or a word access with a[1:0]!=00 SHALL set misalign, skip REQ (no mem_req), go directly to RESP, pulse done and leave MDR unchanged; misalign SHALL clear on the next start.
REQ-025 When MISALIGN_TRAP_EN is undefined, misalign SHALL be tied 0 and the offending low address bits SHALL be ignored: half uses a[1], word uses lane 0.

Structure
REQ-026 The shared package mem_pkg SHALL hold the Size_s encodings (SZ_B, SZ_H, SZ_W), the FSM state encoding and the timeout counter width.
REQ-027 Lane extraction and extension SHALL be a combinational sub-module mem_ext (inputs: rdata, a[1:0], size, SE_s; output: 32-bit result), reused by the register-file write path.

Verification
REQ-028 The bench SHALL cover a byte load: addr=0x103, size=00, SE_s=0, mem_rdata=0x80xxxxxx, ack on first REQ cycle -> mem_be=1000, mem_addr=0x100, MDR=0xFFFFFF80, done 3 cycles after start.
REQ-029 The bench SHALL cover a half load, zero-extend: addr=0x202, size=01, SE_s=1, rdata=0xBEEF1234 -> be=1100, MDR=0x0000BEEF.
REQ-030 The bench SHALL cover a byte store: addr=0x301, wdata=0x000000A5 -> mem_we=1, be=0010, mem_wdata=0xA5A5A5A5, MDR unchanged.
REQ-031 The bench SHALL cover a timeout: TO_CYCLES=15, mem_ack held 0 -> mem_req high 15 cycles then low, err=1, one done pulse; a new start clears err.
REQ-032 The bench SHALL cover reset during REQ: rst_ pulsed low -> all outputs 0 immediately, no done; a following start works normally.
REQ-033 With MISALIGN_TRAP_EN defined, the bench SHALL cover a word load at addr=0x402 -> misalign=1, no mem_req, done 2 cycles after start.
